// File: rtl/alu4_result_collector.sv
// alu4_result_collector
// Collects per-nibble outputs of the 4-bit ALU slice into one wide word.
// Each nibble carries 4 result bits and 4 flag bits. The word is built LSB
// nibble first and handed to a consumer through a single-entry output register.
//
// State table:
//   IDLE  | no word in progress, waiting for an sop nibble
//   ACCUM | word in progress, idx_q is the next nibble position
//   HOLD  | completed word held in output register until out_ready
//
// Ports:
//   clk, rst_n         clock (rising edge), async active-low reset
//   in_valid/in_ready  nibble handshake
//   in_sop             nibble is nibble 0 of a new word
//   in_res, in_flg     ALU result and flag nibbles
//   out_valid/ready    assembled word handshake
//   out_word           assembled word, nibble 0 in bits [3:0]
//   out_flg_last       flags of the most significant nibble
//   out_flg_any        OR of all flag nibbles of the word
//   out_zero           out_word == 0, registered with the word
//   err_cnt            saturating count of dropped or orphaned nibbles/words
module alu4_result_collector #(
  parameter int NIBBLES = 4,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sop,
  input  logic [3:0]           in_res,
  input  logic [3:0]           in_flg,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] out_word,
  output logic [3:0]           out_flg_last,
  output logic [3:0]           out_flg_any,
  output logic                 out_zero,
  output logic [CNT_W-1:0]     err_cnt
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     acc_q, acc_d;
  logic [3:0]       flg_acc_q, flg_acc_d;
  logic [W-1:0]     out_word_q, out_word_d;
  logic [3:0]       out_flg_last_q, out_flg_last_d;
  logic [3:0]       out_flg_any_q, out_flg_any_d;
  logic             out_zero_q, out_zero_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic         accept;
  logic         err_inc;
  logic [W-1:0] word_full;
  logic [3:0]   flg_full;

  assign in_ready = (state_q != HOLD) | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    acc_d          = acc_q;
    flg_acc_d      = flg_acc_q;
    out_word_d     = out_word_q;
    out_flg_last_d = out_flg_last_q;
    out_flg_any_d  = out_flg_any_q;
    out_zero_d     = out_zero_q;
    err_cnt_d      = err_cnt_q;
    err_inc        = 1'b0;

    // Accumulator with the incoming nibble merged in; only consumed on accept,
    // so undriven data outside a handshake never reaches a flop.
    word_full                   = acc_q;
    word_full[{idx_q, 2'b00} +: 4] = in_res;
    flg_full                    = flg_acc_q | in_flg;

    // Handoff frees the output register; a same-cycle nibble is then
    // treated exactly as in IDLE.
    if (state_q == HOLD && out_ready) begin
      state_d = IDLE;
    end

    if (accept) begin
      if (in_sop) begin
        if (state_q == ACCUM) begin
          err_inc = 1'b1;
        end
        state_d   = ACCUM;
        idx_d     = IDX_W'(1);
        acc_d     = W'(in_res);
        flg_acc_d = in_flg;
      end else if (state_q == ACCUM) begin
        acc_d     = word_full;
        flg_acc_d = flg_full;
        if (idx_q == LAST_IDX) begin
          out_word_d     = word_full;
          out_flg_last_d = in_flg;
          out_flg_any_d  = flg_full;
          out_zero_d     = (word_full == '0);
          idx_d          = '0;
          state_d        = HOLD;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end else begin
        err_inc = 1'b1;
      end
    end

    if (err_inc && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      idx_q          <= '0;
      acc_q          <= '0;
      flg_acc_q      <= '0;
      out_word_q     <= '0;
      out_flg_last_q <= '0;
      out_flg_any_q  <= '0;
      out_zero_q     <= 1'b1;
      err_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      acc_q          <= acc_d;
      flg_acc_q      <= flg_acc_d;
      out_word_q     <= out_word_d;
      out_flg_last_q <= out_flg_last_d;
      out_flg_any_q  <= out_flg_any_d;
      out_zero_q     <= out_zero_d;
      err_cnt_q      <= err_cnt_d;
    end
  end

  assign out_valid    = (state_q == HOLD);
  assign out_word     = out_word_q;
  assign out_flg_last = out_flg_last_q;
  assign out_flg_any  = out_flg_any_q;
  assign out_zero     = out_zero_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_alu4_result_collector.sv
// Directed bench for alu4_result_collector with NIBBLES=4, CNT_W=2.
module tb_alu4_result_collector;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_sop;
  logic [3:0]  in_res;
  logic [3:0]  in_flg;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_word;
  logic [3:0]  out_flg_last;
  logic [3:0]  out_flg_any;
  logic        out_zero;
  logic [1:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  alu4_result_collector #(.NIBBLES(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sop(in_sop),
    .in_res(in_res), .in_flg(in_flg),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_flg_last(out_flg_last),
    .out_flg_any(out_flg_any), .out_zero(out_zero), .err_cnt(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one nibble for exactly one clock edge; data goes to X afterwards.
  task automatic nib(input logic sop, input logic [3:0] res, input logic [3:0] flg);
    in_valid = 1'b1;
    in_sop   = sop;
    in_res   = res;
    in_flg   = flg;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_res   = 4'bx;
    in_flg   = 4'bx;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_res    = 4'bx;
    in_flg    = 4'bx;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    chk("rst_out_zero", 32'(out_zero), 32'h1);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_word", 32'(out_word), 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic word
    nib(1'b1, 4'h1, 4'h1);
    nib(1'b0, 4'h2, 4'h0);
    nib(1'b0, 4'h3, 4'h4);
    chk("basic_not_valid_yet", 32'(out_valid), 32'h0);
    nib(1'b0, 4'h4, 4'h2);
    chk("basic_valid", 32'(out_valid), 32'h1);
    chk("basic_word", 32'(out_word), 32'h4321);
    chk("basic_flg_last", 32'(out_flg_last), 32'h2);
    chk("basic_flg_any", 32'(out_flg_any), 32'h7);
    chk("basic_zero", 32'(out_zero), 32'h0);
    idle_cycle();
    chk("basic_handoff", 32'(out_valid), 32'h0);

    // Zero word
    nib(1'b1, 4'h0, 4'h0);
    nib(1'b0, 4'h0, 4'h0);
    nib(1'b0, 4'h0, 4'h0);
    nib(1'b0, 4'h0, 4'h8);
    chk("zero_valid", 32'(out_valid), 32'h1);
    chk("zero_word", 32'(out_word), 32'h0);
    chk("zero_zero", 32'(out_zero), 32'h1);
    chk("zero_flg_any", 32'(out_flg_any), 32'h8);
    chk("zero_flg_last", 32'(out_flg_last), 32'h8);
    idle_cycle();

    // Backpressure with a waiting sop nibble
    out_ready = 1'b0;
    nib(1'b1, 4'h1, 4'h0);
    nib(1'b0, 4'hB, 4'h0);
    nib(1'b0, 4'hC, 4'h0);
    nib(1'b0, 4'hD, 4'h0);
    chk("bp_in_ready_low", 32'(in_ready), 32'h0);
    in_valid = 1'b1;
    in_sop   = 1'b1;
    in_res   = 4'hA;
    in_flg   = 4'h1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_held", 32'(out_valid), 32'h1);
      chk("bp_word_stable", 32'(out_word), 32'hDCB1);
      chk("bp_in_ready_held", 32'(in_ready), 32'h0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rise", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_res   = 4'bx;
    in_flg   = 4'bx;
    chk("bp_handoff", 32'(out_valid), 32'h0);
    nib(1'b0, 4'h9, 4'h0);
    nib(1'b0, 4'h8, 4'h0);
    nib(1'b0, 4'h7, 4'h0);
    chk("bp_next_valid", 32'(out_valid), 32'h1);
    chk("bp_next_word", 32'(out_word), 32'h789A);
    chk("bp_next_flg_any", 32'(out_flg_any), 32'h1);
    chk("bp_err_cnt", 32'(err_cnt), 32'h0);
    idle_cycle();

    // Restart: partial word 5,6 dropped
    nib(1'b1, 4'h5, 4'h4);
    nib(1'b0, 4'h6, 4'h8);
    nib(1'b1, 4'h9, 4'h1);
    chk("restart_err", 32'(err_cnt), 32'h1);
    nib(1'b0, 4'h8, 4'h0);
    nib(1'b0, 4'h7, 4'h0);
    nib(1'b0, 4'h6, 4'h2);
    chk("restart_valid", 32'(out_valid), 32'h1);
    chk("restart_word", 32'(out_word), 32'h6789);
    chk("restart_flg_any", 32'(out_flg_any), 32'h3);
    chk("restart_flg_last", 32'(out_flg_last), 32'h2);
    // Non-sop nibble during handoff is discarded
    nib(1'b0, 4'h3, 4'hF);
    chk("hold_orphan_err", 32'(err_cnt), 32'h2);
    chk("hold_orphan_valid", 32'(out_valid), 32'h0);
    chk("hold_orphan_word", 32'(out_word), 32'h6789);

    // Reset in the middle of a word
    nib(1'b1, 4'h1, 4'h1);
    nib(1'b0, 4'h2, 4'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'h0);
    chk("midrst_err", 32'(err_cnt), 32'h0);
    chk("midrst_zero", 32'(out_zero), 32'h1);
    chk("midrst_word", 32'(out_word), 32'h0);
    #2;
    rst_n = 1'b1;
    nib(1'b1, 4'hF, 4'h0);
    nib(1'b0, 4'hE, 4'h0);
    nib(1'b0, 4'hD, 4'h0);
    nib(1'b0, 4'hC, 4'h0);
    chk("postrst_valid", 32'(out_valid), 32'h1);
    chk("postrst_word", 32'(out_word), 32'hCDEF);
    chk("postrst_flg_any", 32'(out_flg_any), 32'h0);
    chk("postrst_err", 32'(err_cnt), 32'h0);
    idle_cycle();

    // Orphans in IDLE saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      nib(1'b0, 4'h5, 4'h5);
      chk("orphan_err", 32'(err_cnt), (i < 3) ? 32'(i + 1) : 32'h3);
      chk("orphan_valid", 32'(out_valid), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu4_result_collector.md
Name: alu4_result_collector

Overview:
- Downstream stage of the 4-bit combinational ALU slice.
- Captures successive per-nibble ALU outputs (4 result bits plus 4 flag bits) under a valid/ready handshake.
- Assembles NIBBLES nibbles, LSB nibble first, into one wide result word with accumulated flags.
- Presents each completed word to the consumer through a single-entry output register with backpressure.

Parameters:
NIBBLES, 4, nibbles per assembled word (legal 2..8); word width W = 4*NIBBLES
CNT_W, 8, width of saturating restart-error counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  nibble present on in_res/in_flg
in_ready  output  1  collector accepts nibble this cycle
in_sop  input  1  nibble is first (least significant) of a word
in_res  input  4  ALU result nibble (o,p,q,r order: o = bit 0)
in_flg  input  4  ALU flag nibble (s,t,u,v order: s = bit 0)
out_valid  output  1  assembled word available
out_ready  input  1  consumer accepts word
out_word  output  W  assembled result, nibble 0 in bits [3:0]
out_flg_last  output  4  flag nibble of final (most significant) slice
out_flg_any  output  4  OR of all flag nibbles in the word
out_zero  output  1  out_word == 0
err_cnt  output  CNT_W  count of restarted/dropped partial words, saturating

Behaviour:
- Reset (async assert, sync-release use at clk edge):
  - state = IDLE, nibble index = 0.
  - out_valid = 0; out_word, out_flg_last, out_flg_any = 0.
  - out_zero = 1; err_cnt = 0; in_ready = 1.
- Accept event: in_valid & in_ready at rising edge.
- States:
  - IDLE:
    - Accept with in_sop=1: store nibble 0, idx=1, flg_any=in_flg, go ACCUM.
    - Accept with in_sop=0: discard nibble, err_cnt+1, stay IDLE.
  - ACCUM:
    - Accept with in_sop=0: store nibble at idx; flg_any |= in_flg; idx+1.
    - When stored nibble is idx = NIBBLES-1: load output register (word, out_flg_last=in_flg, out_flg_any, out_zero), idx=0, go HOLD.
    - Accept with in_sop=1: partial word discarded, err_cnt+1; nibble taken as new nibble 0 (idx=1, flg_any=in_flg); stay ACCUM.
  - HOLD:
    - out_valid = 1; outputs stable until out_ready.
    - On out_valid & out_ready: out_valid falls next cycle, go IDLE.
- in_ready = (state != HOLD) | out_ready.
  - In HOLD with out_ready=1, a same-cycle accepted in_sop nibble proceeds as in IDLE: go ACCUM (idx=1), skipping IDLE.
  - In HOLD with out_ready=1, an accepted non-sop nibble is discarded with err_cnt+1.
- Latency: out_valid asserts the cycle after the last nibble is accepted. Zero bubbles between words when out_ready held high. Throughput: one nibble per cycle.
- err_cnt saturates at 2^CNT_W-1; never wraps.
- out_zero is registered with out_word. It is computed over all W bits, including the final nibble being loaded.
- Flag OR restarts on every accepted sop nibble; flags from a discarded partial word never reach out_flg_any.
- in_res and in_flg are ignored when in_valid=0. No X propagation into state from undriven data when not accepting.
- Reset mid-word or mid-HOLD: everything returns to reset values immediately; the partial word is lost and not counted in err_cnt.

Test Plan:
- Reset: rst_n low mid-ACCUM (2 nibbles in) -> out_valid=0, err_cnt=0, out_zero=1 asynchronously; next sop word assembles cleanly.
- Basic word, NIBBLES=4, out_ready=1: nibbles 0x1,0x2,0x3,0x4 (sop on first), flg 0x1,0x0,0x4,0x2 -> out_word=0x4321, out_flg_last=0x2, out_flg_any=0x7, out_zero=0, out_valid one cycle after 4th accept.
- Zero word: nibbles 0,0,0,0 with flg 0x8 on last -> out_word=0x0000, out_zero=1, out_flg_any=0x8.
- Backpressure: out_ready=0 for 5 cycles after word done -> in_ready=0 and outputs stable. Raise out_ready with an sop nibble 0xA waiting -> word handed off; 0xA accepted the same cycle as nibble 0 of the next word.
- Restart error: sop, 0x5, 0x6, then sop 0x9,0x8,0x7,0x6 -> err_cnt=1, out_word=0x6789, out_flg_any excludes flags of 0x5/0x6.
- Orphan nibbles and saturation, CNT_W=2: five non-sop nibbles in IDLE -> err_cnt=3 (saturated), out_valid stays 0.
